// File: rtl/can_pkg.sv
// Shared CAN receive-path definitions: destuffer state encoding,
// nominal stuff run length and bus bit levels.
package can_pkg;

  // Destuffer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2,
    ERR   = 2'd3
  } destuff_state_t;

  // Consecutive equal bits after which CAN inserts a complementary stuff bit
  localparam int CAN_STUFF_RUN_LEN = 5;

  // Bus levels
  localparam logic BIT_RECESSIVE = 1'b1;
  localparam logic BIT_DOMINANT  = 1'b0;

endpackage

// File: rtl/can_bit_destuff.sv
// CAN bit destuffer: drops the stuff bit that follows RUN_LEN equal bits,
// forwards payload bits one cycle after their strobe, and flags a stuff error
// when the expected complementary bit does not appear.
// Optional build macro: CAN_DESTUFF_STATS_EN adds the stuff_cnt output, a
// saturating count of stuff bits removed in the current frame.
module can_bit_destuff
  import can_pkg::*;
#(
  parameter int RUN_LEN = CAN_STUFF_RUN_LEN,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             din_valid,
  output logic             dout,
  output logic             dout_valid,
  output logic             stuff_err
`ifdef CAN_DESTUFF_STATS_EN
  ,
  output logic [CNT_W-1:0] stuff_cnt
`endif
);

  localparam int RUN_W = $clog2(RUN_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  // A one-bit run length would make every bit (even the first) complete a run
  localparam destuff_state_t NEW_RUN_STATE = (RUN_LEN == 1) ? STUFF : RUN;

  if (RUN_LEN < 1 || CNT_W < 1) begin : g_bad_param
    $error("can_bit_destuff: RUN_LEN and CNT_W must be at least 1");
  end

  destuff_state_t   r_state;
  logic [RUN_W-1:0] r_run_cnt;
  logic             r_last_bit;
  logic             r_armed;      // en has been seen low since reset
  logic             r_dout;
  logic             r_dout_valid;
  logic             r_stuff_err;

  logic             w_strobe;
  logic             w_same;
  logic [RUN_W-1:0] w_run_next;
  logic             w_frame_start;
  logic             w_stuff_ok;

  assign w_strobe      = en & din_valid;
  assign w_same        = (din == r_last_bit);
  assign w_run_next    = w_same ? (r_run_cnt + RUN_ONE) : RUN_ONE;
  assign w_frame_start = w_strobe & r_armed & (r_state == IDLE);
  assign w_stuff_ok    = w_strobe & (r_state == STUFF) & ~w_same;

  // Destuffing FSM with registered outputs; en low overrides any strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_run_cnt    <= '0;
      r_last_bit   <= BIT_RECESSIVE;
      r_armed      <= 1'b0;
      r_dout       <= BIT_RECESSIVE;
      r_dout_valid <= 1'b0;
      r_stuff_err  <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (!en) begin
        r_state     <= IDLE;
        r_run_cnt   <= '0;
        r_last_bit  <= BIT_RECESSIVE;
        r_stuff_err <= 1'b0;
        r_armed     <= 1'b1;
      end else if (din_valid) begin
        case (r_state)
          IDLE: begin
            // SOF: forwarded and starts the first run
            if (w_frame_start) begin
              r_dout       <= din;
              r_dout_valid <= 1'b1;
              r_last_bit   <= din;
              r_run_cnt    <= RUN_ONE;
              r_state      <= NEW_RUN_STATE;
            end
          end
          RUN: begin
            r_dout       <= din;
            r_dout_valid <= 1'b1;
            r_last_bit   <= din;
            r_run_cnt    <= w_run_next;
            r_state      <= (w_run_next == RUN_MAX) ? STUFF : RUN;
          end
          STUFF: begin
            // Stuff bit is dropped but begins the next run
            if (w_stuff_ok) begin
              r_last_bit <= din;
              r_run_cnt  <= RUN_ONE;
              r_state    <= NEW_RUN_STATE;
            end else begin
              r_stuff_err <= 1'b1;
              r_state     <= ERR;
            end
          end
          ERR: begin
            // Frame is dead until en drops
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef CAN_DESTUFF_STATS_EN
  logic [CNT_W-1:0] r_stuff_cnt;

  // Saturating per-frame stuff bit counter, cleared at frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stuff_cnt <= '0;
    end else if (w_frame_start) begin
      r_stuff_cnt <= '0;
    end else if (w_stuff_ok && (r_stuff_cnt != {CNT_W{1'b1}})) begin
      r_stuff_cnt <= r_stuff_cnt + 1'b1;
    end
  end

  assign stuff_cnt = r_stuff_cnt;
`endif

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign stuff_err  = r_stuff_err;

endmodule

// File: doc/can_bit_destuff.md
Name: can_bit_destuff

Overview:
- Receive-path stage directly downstream of the mid-bit sampler. It consumes one sampled bit per strobe, `din` qualified by `din_valid`.
- Removes CAN stuff bits: after RUN_LEN consecutive equal bits, the next bit is a stuff bit and is dropped.
- Flags stuff errors.
- Forwards only payload bits to the frame deserializer, one registered bit per accepted strobe.

Parameters:
- RUN_LEN, 5: number of consecutive equal bits after which a stuff bit is expected.
- CNT_W, 8: width of the optional stuff-bit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  frame window. High from SOF through end of CRC field; low elsewhere.
- din  in  1  sampled bus bit
- din_valid  in  1  one-cycle strobe, one per CAN bit period
- dout  out  1  destuffed data bit
- dout_valid  out  1  one-cycle strobe, dout valid
- stuff_err  out  1  stuff-rule violation, sticky while en high
- stuff_cnt  out  CNT_W  stuff bits removed in current frame (only with DESTUFF_STATS_EN)

Behaviour:
- Reset values: dout=1 (recessive), dout_valid=0, stuff_err=0, stuff_cnt=0. Internal: run_cnt=0, last_bit=1, state=IDLE.
- Only clk edges with din_valid=1 are processed. din is ignored when din_valid=0.
- States:
  - IDLE: entered on reset or en=0.
  - RUN: counting equal bits.
  - STUFF: next valid bit is a stuff bit.
  - ERR: violation seen.
- IDLE -> RUN on the first din_valid with en=1. That bit is SOF: forwarded, last_bit=din, run_cnt=1.
- RUN, valid bit:
  - Always forwarded: dout=din, dout_valid=1 on the following cycle.
  - If din==last_bit: run_cnt+1, else run_cnt=1 and last_bit=din.
  - When run_cnt reaches RUN_LEN: go to STUFF.
- STUFF, valid bit:
  - din != last_bit: bit dropped (dout_valid stays 0). last_bit=din, run_cnt=1, stuff_cnt+1, back to RUN. The stuff bit starts the new run.
  - din == last_bit: stuff_err=1, bit dropped, go to ERR.
- ERR: no further dout_valid. stuff_err held high until en=0.
- en=0 in any state → next cycle:
  - IDLE, run_cnt=0, last_bit=1, stuff_err=0, dout_valid=0.
  - stuff_cnt holds its value until the next frame start, and clears on the IDLE->RUN transition.
- en falling on the same cycle as din_valid: en wins. The bit is discarded and no dout_valid is issued.
- Latency: exactly 1 clk from a din_valid edge to the dout_valid pulse. dout_valid is never high two consecutive cycles for legal input (one strobe per bit period).
- dout keeps its last value between strobes.
- run_cnt width is clog2(RUN_LEN+1). It never exceeds RUN_LEN.
- stuff_cnt saturates at all-ones; it does not wrap.
- rst asserted mid-frame: all outputs return to reset values immediately (asynchronous). Processing resumes only after en has been seen low then high, i.e. at the next frame start.

Optional Feature:
- Macro: CAN_DESTUFF_STATS_EN.
- Defined: stuff_cnt port and counter present, behaviour as above.
- Undefined: the port is absent and the counter logic is removed. All other behaviour is identical.

Decomposition:
- Shared package `can_pkg` holds:
  - state encoding constants: IDLE, RUN, STUFF, ERR;
  - CAN_STUFF_RUN_LEN = 5;
  - recessive/dominant bit constants (1/0).
- No sub-module needed: a single FSM plus counters; a split would be artificial.

Test Plan:
1. Stream `0 0 0 0 0 1 1 0` with en=1, one strobe per 1 us → six dout_valid pulses carrying `0 0 0 0 0 1`, then `0`. The sixth input bit is dropped, stuff_cnt=1, stuff_err=0.
2. Stream `1 1 1 1 1 0 0 0 0 1` → no bits dropped except the 0 after five 1s. That 0 starts a run; the following three 0s make run_cnt=4, so no stuff is expected. Forwarded: `1 1 1 1 1 0 0 0 1`, stuff_cnt=1.
3. Stream `0 0 0 0 0 0` → stuff_err rises 1 cycle after the sixth strobe, with no sixth dout_valid. Further strobes give no dout_valid. Dropping en clears stuff_err next cycle.
4. Back-to-back stuffing `0x5 ×0, 1(stuff), 1 1 1 1, 0(stuff), 0` → stuff_cnt=2. The stuff bit counts as the first bit of the next run.
5. rst pulse asserted mid-run after 3 equal bits → outputs reset asynchronously. Then en low→high followed by `0 0 0 0 0 1` → the stuff bit is detected only after five fresh bits; no carry-over from before the reset.
6. en deasserted on the same clk as a din_valid → no dout_valid. The next frame starts from IDLE with stuff_cnt cleared to 0.
